// File: rtl/lock_sequencer_pkg.sv
// Shared definitions for the lock sequencer: sequencer state encoding,
// lock-loss counter width and a counter sizing helper.
package lock_sequencer_pkg;

    // Sequencer states; the encoding is visible on the seq_state output.
    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLDOFF   = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

    localparam int unsigned STATE_W    = 2;
    localparam int unsigned LOSS_CNT_W = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

    // Bits needed to hold max_val without wrapping; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : lock_sequencer_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous flags.
// Each bit is synchronized on its own; no coherency between bits is implied.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears both flop stages
//   d_i    : asynchronous input bits
//   q_o    : synchronized bits, two clk_i edges of latency
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability stage followed by the settled stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/lock_sequencer.sv
// Turns asynchronous DCM lock flags into staged active-low resets.
// The lock flags are synchronized and ANDed, qualified by a run-length
// filter, followed by a hold-off wait, after which the reset outputs are
// released one stage at a time. Losing lock in RELEASE or RUN drops every
// reset output at once and bumps a saturating loss counter.
//   input_clk       : single clock
//   reset_n         : asynchronous active-low reset
//   locked_in       : raw lock flags, asynchronous to input_clk
//   sys_reset_n     : staged active-low resets, bit 0 released first
//   all_locked      : qualified lock (HOLDOFF, RELEASE or RUN)
//   lock_loss_count : saturating count of lock-loss events
//   seq_state       : current sequencer state
// All outputs are registered copies of the internal sequencer state.
module lock_sequencer
    import lock_sequencer_pkg::*;
#(
    parameter int unsigned NUM_LOCKS      = 2,
    parameter int unsigned LOCK_FILTER    = 16,
    parameter int unsigned HOLDOFF_CYCLES = 1000,
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned STAGE_GAP      = 16
) (
    input  logic                  input_clk,
    input  logic                  reset_n,
    input  logic [NUM_LOCKS-1:0]  locked_in,
    output logic [NUM_STAGES-1:0] sys_reset_n,
    output logic                  all_locked,
    output logic [LOSS_CNT_W-1:0] lock_loss_count,
    output logic [STATE_W-1:0]    seq_state
);

    localparam int unsigned FILT_W = cnt_width(LOCK_FILTER);
    localparam int unsigned HOLD_W = cnt_width(HOLDOFF_CYCLES - 1);
    localparam int unsigned GAP_W  = cnt_width(STAGE_GAP - 1);

    localparam logic [FILT_W-1:0]     FILT_MAX  = FILT_W'(LOCK_FILTER);
    localparam logic [FILT_W-1:0]     FILT_ARM  = FILT_W'(LOCK_FILTER - 1);
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [NUM_STAGES-1:0] REL_FIRST = NUM_STAGES'(1);

    // ------------------------------------------------------------------
    // Lock synchronization
    // ------------------------------------------------------------------
    logic [NUM_LOCKS-1:0] lock_sync;
    logic                 lk;

    sync_2ff #(
        .WIDTH (NUM_LOCKS)
    ) u_lock_sync (
        .clk_i  (input_clk),
        .rst_ni (reset_n),
        .d_i    (locked_in),
        .q_o    (lock_sync)
    );

    // Clocks count as locked only when every synchronized flag is high.
    assign lk = &lock_sync;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    seq_state_e              state_q, state_d;
    logic [FILT_W-1:0]       filt_q, filt_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [NUM_STAGES-1:0]   rel_q, rel_d;
    logic [LOSS_CNT_W-1:0]   loss_q, loss_d;

    logic [NUM_STAGES-1:0]   rel_next_c;
    logic [LOSS_CNT_W-1:0]   loss_inc_c;

    // Released bits form a thermometer code, so the next stage is one shift away.
    assign rel_next_c = rel_q | (rel_q << 1);
    assign loss_inc_c = (loss_q == LOSS_CNT_MAX) ? loss_q : loss_q + LOSS_CNT_W'(1);

    // State register and counters.
    always_ff @(posedge input_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_WAIT_LOCK;
            filt_q  <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            rel_q   <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            rel_q   <= rel_d;
            loss_q  <= loss_d;
        end
    end

    // Next-state logic. Lock loss is checked before any timer terminal
    // count so a coincident loss always wins over a release.
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        rel_d   = rel_q;
        loss_d  = loss_q;

        // Run-length filter on lk, saturating at LOCK_FILTER.
        if (!lk) begin
            filt_d = '0;
        end else if (filt_q != FILT_MAX) begin
            filt_d = filt_q + FILT_W'(1);
        end

        unique case (state_q)
            ST_WAIT_LOCK: begin
                rel_d  = '0;
                hold_d = '0;
                gap_d  = '0;
                if (lk && (filt_q == FILT_ARM)) begin
                    state_d = ST_HOLDOFF;
                end
            end

            ST_HOLDOFF: begin
                if (!lk) begin
                    // Lock never reached the outputs, so it is not a loss event.
                    state_d = ST_WAIT_LOCK;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
                    rel_d   = REL_FIRST;
                    hold_d  = '0;
                    gap_d   = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            ST_RELEASE: begin
                if (!lk) begin
                    state_d = ST_WAIT_LOCK;
                    rel_d   = '0;
                    gap_d   = '0;
                    loss_d  = loss_inc_c;
                end else if (gap_q == GAP_LAST) begin
                    rel_d = rel_next_c;
                    gap_d = '0;
                    if (rel_next_c[NUM_STAGES-1]) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            ST_RUN: begin
                if (!lk) begin
                    state_d = ST_WAIT_LOCK;
                    rel_d   = '0;
                    gap_d   = '0;
                    loss_d  = loss_inc_c;
                end
            end

            default: begin
                state_d = ST_WAIT_LOCK;
                rel_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [NUM_STAGES-1:0] sys_reset_n_q;
    logic                  all_locked_q;
    logic [LOSS_CNT_W-1:0] lock_loss_count_q;
    logic [STATE_W-1:0]    seq_state_q;

    // Registered copies keep locked_in away from any output by a flop.
    always_ff @(posedge input_clk or negedge reset_n) begin
        if (!reset_n) begin
            sys_reset_n_q     <= '0;
            all_locked_q      <= 1'b0;
            lock_loss_count_q <= '0;
            seq_state_q       <= '0;
        end else begin
            sys_reset_n_q     <= rel_q;
            all_locked_q      <= (state_q != ST_WAIT_LOCK);
            lock_loss_count_q <= loss_q;
            seq_state_q       <= state_q;
        end
    end

    assign sys_reset_n     = sys_reset_n_q;
    assign all_locked      = all_locked_q;
    assign lock_loss_count = lock_loss_count_q;
    assign seq_state       = seq_state_q;

endmodule : lock_sequencer

// File: tb/tb_lock_sequencer.sv
// Testbench for lock_sequencer with small timing parameters.
// A table of {locked_in, hold ticks, expected outputs} records drives the
// main scenarios; each record pushes its expectation to a scoreboard queue
// that is popped when the tick it names is reached. Saturation and the
// asynchronous reset are hand-written sequences.
module tb_lock_sequencer;

    localparam int unsigned NL  = 2;
    localparam int unsigned LF  = 4;
    localparam int unsigned HO  = 8;
    localparam int unsigned NS  = 3;
    localparam int unsigned GAP = 2;

    logic          input_clk;
    logic          reset_n;
    logic [NL-1:0] locked_in;
    logic [NS-1:0] sys_reset_n;
    logic          all_locked;
    logic [7:0]    lock_loss_count;
    logic [1:0]    seq_state;

    lock_sequencer #(
        .NUM_LOCKS      (NL),
        .LOCK_FILTER    (LF),
        .HOLDOFF_CYCLES (HO),
        .NUM_STAGES     (NS),
        .STAGE_GAP      (GAP)
    ) dut (
        .input_clk       (input_clk),
        .reset_n         (reset_n),
        .locked_in       (locked_in),
        .sys_reset_n     (sys_reset_n),
        .all_locked      (all_locked),
        .lock_loss_count (lock_loss_count),
        .seq_state       (seq_state)
    );

    initial begin
        input_clk = 1'b0;
        forever #5 input_clk = ~input_clk;
    end

    typedef struct {
        logic [NL-1:0] lock;
        int unsigned   ticks;
        logic [NS-1:0] srn;
        logic          al;
        logic [7:0]    cnt;
        logic [1:0]    st;
    } vec_t;

    typedef struct {
        int unsigned   at;
        logic [NS-1:0] srn;
        logic          al;
        logic [7:0]    cnt;
        logic [1:0]    st;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        tbl[$];
    int unsigned tick_no  = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned exp_cnt;

    task automatic chk(input string name, input int unsigned at,
                       input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s @tick %0d: got 0x%0h, want 0x%0h", name, at, act, exp_v);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [NS-1:0] srn, input logic al,
                               input logic [7:0] cnt, input logic [1:0] st);
        chk({tag, ".sys_reset_n"}, tick_no, 32'(sys_reset_n), 32'(srn));
        chk({tag, ".all_locked"}, tick_no, 32'(all_locked), 32'(al));
        chk({tag, ".lock_loss_count"}, tick_no, 32'(lock_loss_count), 32'(cnt));
        chk({tag, ".seq_state"}, tick_no, 32'(seq_state), 32'(st));
    endtask

    // One clock edge; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        exp_t e;
        @(posedge input_clk);
        #1;
        tick_no++;
        while (sb_q.size() > 0 && sb_q[0].at <= tick_no) begin
            e = sb_q.pop_front();
            if (e.at != tick_no) begin
                n_checks++;
                $display("FAIL sb_timing: expectation for tick %0d seen at tick %0d", e.at, tick_no);
            end
            chk_outputs("sb", e.srn, e.al, e.cnt, e.st);
        end
    endtask

    function automatic vec_t mkv(input logic [NL-1:0] lock, input int unsigned t,
                                 input logic [NS-1:0] srn, input logic al,
                                 input logic [7:0] cnt, input logic [1:0] st);
        vec_t v;
        v.lock  = lock;
        v.ticks = t;
        v.srn   = srn;
        v.al    = al;
        v.cnt   = cnt;
        v.st    = st;
        return v;
    endfunction

    // Drive one record; its expectation is due at the last of its ticks.
    task automatic run_vec(input vec_t v);
        exp_t e;
        locked_in = v.lock;
        e.at  = tick_no + v.ticks;
        e.srn = v.srn;
        e.al  = v.al;
        e.cnt = v.cnt;
        e.st  = v.st;
        sb_q.push_back(e);
        repeat (v.ticks) tick();
    endtask

    // Clean lock timeline: the first tick of the first record is edge 0.
    task automatic push_clean(input logic [7:0] c);
        tbl.push_back(mkv(2'b11, 6, 3'b000, 1'b0, c, 2'd0));  // edge 5
        tbl.push_back(mkv(2'b11, 1, 3'b000, 1'b1, c, 2'd1));  // edge 6: all_locked
        tbl.push_back(mkv(2'b11, 7, 3'b000, 1'b1, c, 2'd1));  // edge 13
        tbl.push_back(mkv(2'b11, 1, 3'b001, 1'b1, c, 2'd2));  // edge 14: stage 0
        tbl.push_back(mkv(2'b11, 1, 3'b001, 1'b1, c, 2'd2));  // edge 15
        tbl.push_back(mkv(2'b11, 1, 3'b011, 1'b1, c, 2'd2));  // edge 16: stage 1
        tbl.push_back(mkv(2'b11, 1, 3'b011, 1'b1, c, 2'd2));  // edge 17
        tbl.push_back(mkv(2'b11, 1, 3'b111, 1'b1, c, 2'd3));  // edge 18: stage 2, RUN
        tbl.push_back(mkv(2'b11, 5, 3'b111, 1'b1, c, 2'd3));  // edge 23
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        locked_in = '0;

        // Glitch in WAIT_LOCK: filter reaches LOCK_FILTER-1 but never arms.
        tbl.push_back(mkv(2'b11, 3, 3'b000, 1'b0, 8'd0, 2'd0));
        tbl.push_back(mkv(2'b01, 3, 3'b000, 1'b0, 8'd0, 2'd0));
        tbl.push_back(mkv(2'b01, 5, 3'b000, 1'b0, 8'd0, 2'd0));
        // Clean lock.
        push_clean(8'd0);
        // Loss in RUN, first sampled at edge L: outputs respond at L+3.
        tbl.push_back(mkv(2'b01, 2, 3'b111, 1'b1, 8'd0, 2'd3));  // L+1
        tbl.push_back(mkv(2'b01, 1, 3'b111, 1'b1, 8'd0, 2'd3));  // L+2
        tbl.push_back(mkv(2'b01, 1, 3'b000, 1'b0, 8'd1, 2'd0));  // L+3
        tbl.push_back(mkv(2'b01, 4, 3'b000, 1'b0, 8'd1, 2'd0));
        // Re-lock, then drop at edge 13 so the loss lands on the stage-1 release edge.
        tbl.push_back(mkv(2'b11, 6, 3'b000, 1'b0, 8'd1, 2'd0));  // edge 5
        tbl.push_back(mkv(2'b11, 1, 3'b000, 1'b1, 8'd1, 2'd1));  // edge 6
        tbl.push_back(mkv(2'b11, 6, 3'b000, 1'b1, 8'd1, 2'd1));  // edge 12
        tbl.push_back(mkv(2'b01, 1, 3'b000, 1'b1, 8'd1, 2'd1));  // edge 13
        tbl.push_back(mkv(2'b01, 1, 3'b001, 1'b1, 8'd1, 2'd2));  // edge 14
        tbl.push_back(mkv(2'b01, 1, 3'b001, 1'b1, 8'd1, 2'd2));  // edge 15
        tbl.push_back(mkv(2'b01, 1, 3'b000, 1'b0, 8'd2, 2'd0));  // edge 16: bit 1 never rose
        tbl.push_back(mkv(2'b01, 3, 3'b000, 1'b0, 8'd2, 2'd0));
        // Drop at edge 11 so lk=0 meets the hold-off terminal count: no loss counted.
        tbl.push_back(mkv(2'b11, 6, 3'b000, 1'b0, 8'd2, 2'd0));  // edge 5
        tbl.push_back(mkv(2'b11, 1, 3'b000, 1'b1, 8'd2, 2'd1));  // edge 6
        tbl.push_back(mkv(2'b11, 4, 3'b000, 1'b1, 8'd2, 2'd1));  // edge 10
        tbl.push_back(mkv(2'b01, 3, 3'b000, 1'b1, 8'd2, 2'd1));  // edge 13
        tbl.push_back(mkv(2'b01, 1, 3'b000, 1'b0, 8'd2, 2'd0));  // edge 14
        tbl.push_back(mkv(2'b01, 3, 3'b000, 1'b0, 8'd2, 2'd0));
        // Clean lock again after the aborted hold-off.
        push_clean(8'd2);

        // Reset values while reset_n is held low.
        repeat (2) @(posedge input_clk);
        #1;
        chk_outputs("reset", 3'b000, 1'b0, 8'd0, 2'd0);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i]);
        end

        // Saturation: 260 loss events starting from RUN.
        exp_cnt = 2;
        for (int i = 0; i < 260; i++) begin
            run_vec(mkv(2'b11, 19, 3'b111, 1'b1, 8'(exp_cnt), 2'd3));
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            run_vec(mkv(2'b00, 4, 3'b000, 1'b0, 8'(exp_cnt), 2'd0));
        end

        // Asynchronous reset between edges while in RUN.
        run_vec(mkv(2'b11, 19, 3'b111, 1'b1, 8'd255, 2'd3));
        #3;
        reset_n = 1'b0;
        #1;
        chk_outputs("async_rst", 3'b000, 1'b0, 8'd0, 2'd0);
        tick();
        chk_outputs("async_rst_hold", 3'b000, 1'b0, 8'd0, 2'd0);
        reset_n = 1'b1;
        // Lock is still high: the next edge is edge 0 of a fresh sequence.
        run_vec(mkv(2'b11, 6, 3'b000, 1'b0, 8'd0, 2'd0));
        run_vec(mkv(2'b11, 1, 3'b000, 1'b1, 8'd0, 2'd1));
        run_vec(mkv(2'b11, 7, 3'b000, 1'b1, 8'd0, 2'd1));
        run_vec(mkv(2'b11, 1, 3'b001, 1'b1, 8'd0, 2'd2));

        chk("sb_drained", tick_no, 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_lock_sequencer
